// File: rtl/nb_chain_checker.sv
// Reader-side checker for the x/y/z update chain: predicts each triple from the previous one.
// Define NBCHK_BLOCKING_EN to check blocking-assignment semantics instead of nonblocking.
module nb_chain_checker #(
   parameter int X_CONST = 25,
   parameter int Y_ADD   = 13,
   parameter int LOCK_N  = 2,
   parameter int CNT_W   = 16
) (
   input  logic             CLK,
   input  logic             RST_N,
   input  logic             clr,
   input  logic             valid,
   input  logic [7:0]       x_in,
   input  logic [7:0]       y_in,
   input  logic [7:0]       z_in,
   output logic             err,
   output logic [2:0]       err_field,
   output logic             fail,
   output logic             locked,
   output logic [CNT_W-1:0] match_cnt,
   output logic [7:0]       err_cnt,
   output logic [1:0]       state
);

   typedef enum logic [1:0] {S_IDLE = 2'd0, S_CHECK = 2'd1, S_FAIL = 2'd2} st_t;

   localparam logic [7:0] PX     = 8'(X_CONST);
   localparam logic [3:0] LOCK_V = 4'(LOCK_N);

   st_t        st, st_nx;
   logic [3:0] consec;
   logic [7:0] py, pz;
   logic [2:0] mism;
   logic       chk, bad;

`ifdef NBCHK_BLOCKING_EN
   // Blocking order: y and z see the freshly written x, so the prediction is constant.
   localparam logic [7:0] PY_B = 8'(X_CONST + Y_ADD);
   localparam logic [7:0] PZ_B = 8'(X_CONST * int'(PY_B));
   assign py = PY_B;
   assign pz = PZ_B;
`else
   logic [7:0] rx, ry;
   assign py = rx + 8'(Y_ADD);
   assign pz = rx * ry;
`endif

   assign state  = st;
   assign locked = (consec == LOCK_V);

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) st <= S_IDLE;
      else        st <= st_nx;
   end

   always_comb begin
      mism  = {pz != z_in, py != y_in, PX != x_in};
      chk   = valid && !clr && (st != S_IDLE);
      bad   = chk && (mism != 3'b000);
      st_nx = st;
      if (clr) st_nx = S_IDLE;
      else if (valid) begin
         case (st)
            S_IDLE:  st_nx = S_CHECK;
            S_CHECK: if (mism != 3'b000) st_nx = S_FAIL;
            default: st_nx = st;
         endcase
      end
   end

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         err       <= 1'b0;
         err_field <= 3'b000;
         fail      <= 1'b0;
         consec    <= 4'd0;
         match_cnt <= '0;
         err_cnt   <= 8'd0;
`ifndef NBCHK_BLOCKING_EN
         rx        <= 8'd0;
         ry        <= 8'd0;
`endif
      end else if (clr) begin
         err       <= 1'b0;
         err_field <= 3'b000;
         fail      <= 1'b0;
         consec    <= 4'd0;
         match_cnt <= '0;
         err_cnt   <= 8'd0;
`ifndef NBCHK_BLOCKING_EN
         rx        <= 8'd0;
         ry        <= 8'd0;
`endif
      end else begin
         err <= 1'b0;
         if (bad) begin
            err       <= 1'b1;
            err_field <= mism;
            fail      <= 1'b1;
            consec    <= 4'd0;
            if (err_cnt != 8'hFF) err_cnt <= err_cnt + 8'd1;
         end else if (chk) begin
            err_field <= 3'b000;
            if (match_cnt != '1) match_cnt <= match_cnt + 1'b1;
            if (consec != LOCK_V) consec <= consec + 4'd1;
         end
`ifndef NBCHK_BLOCKING_EN
         // Reference follows the observed sample so the checker resyncs after an error.
         if (valid) begin
            rx <= x_in;
            ry <= y_in;
         end
`endif
      end
   end

endmodule

// File: tb/tb_nb_chain_checker.sv
// Directed bench for nb_chain_checker; expected values are hand-derived from the chain equations.
module tb_nb_chain_checker;

   logic        CLK = 1'b0;
   logic        RST_N = 1'b0;
   logic        clr = 1'b0;
   logic        valid = 1'b0;
   logic [7:0]  x_in = 8'd0, y_in = 8'd0, z_in = 8'd0;

   logic        err, fail, locked;
   logic [2:0]  err_field;
   logic [15:0] match_cnt;
   logic [7:0]  err_cnt;
   logic [1:0]  state;

   logic        err4, fail4, locked4;
   logic [2:0]  err_field4;
   logic [3:0]  match_cnt4;
   logic [7:0]  err_cnt4;
   logic [1:0]  state4;

   int n_chk  = 0;
   int n_pass = 0;

   always #5 CLK = ~CLK;

   nb_chain_checker dut (
      .CLK(CLK), .RST_N(RST_N), .clr(clr), .valid(valid),
      .x_in(x_in), .y_in(y_in), .z_in(z_in),
      .err(err), .err_field(err_field), .fail(fail), .locked(locked),
      .match_cnt(match_cnt), .err_cnt(err_cnt), .state(state)
   );

   nb_chain_checker #(.CNT_W(4)) dut4 (
      .CLK(CLK), .RST_N(RST_N), .clr(clr), .valid(valid),
      .x_in(x_in), .y_in(y_in), .z_in(z_in),
      .err(err4), .err_field(err_field4), .fail(fail4), .locked(locked4),
      .match_cnt(match_cnt4), .err_cnt(err_cnt4), .state(state4)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
   endtask

   task automatic chk_zero(input string tag);
      chk({tag, "_err"},   32'(err),       0);
      chk({tag, "_fld"},   32'(err_field), 0);
      chk({tag, "_fail"},  32'(fail),      0);
      chk({tag, "_lock"},  32'(locked),    0);
      chk({tag, "_mcnt"},  32'(match_cnt), 0);
      chk({tag, "_ecnt"},  32'(err_cnt),   0);
      chk({tag, "_state"}, 32'(state),     0);
   endtask

   // Drive one valid triple and return #1 after the sampling edge; valid stays high.
   task automatic send(input logic [7:0] x, input logic [7:0] y, input logic [7:0] z);
      @(negedge CLK);
      valid = 1'b1; x_in = x; y_in = y; z_in = z;
      @(posedge CLK); #1;
   endtask

   task automatic idle(input int n);
      @(negedge CLK);
      valid = 1'b0;
      repeat (n) @(posedge CLK);
      #1;
   endtask

   initial begin
      repeat (2) @(posedge CLK);
      #1 chk_zero("rst");
      @(negedge CLK) RST_N = 1'b1;

`ifdef NBCHK_BLOCKING_EN
      send(10, 10, 10);   chk("b_prime", 32'(err), 0);
      send(25, 38, 182);  chk("b_m1", 32'(err), 0);
      send(25, 38, 182);  chk("b_m2", 32'(err), 0); chk("b_mcnt", 32'(match_cnt), 2);
      @(negedge CLK) clr = 1'b1; valid = 1'b0;
      @(negedge CLK) clr = 1'b0;
      send(10, 10, 10);   chk("b_prime2", 32'(err), 0);
      send(25, 23, 100);  chk("b_nbtrip", 32'(err), 1); chk("b_fld", 32'(err_field), 3'b110);
      chk("b_state", 32'(state), 2);
`else
      // nonblocking chain
      send(10, 10, 10);   chk("nb_prime_err", 32'(err), 0); chk("nb_prime_st", 32'(state), 1);
      chk("nb_prime_mcnt", 32'(match_cnt), 0);
      send(25, 23, 100);  chk("nb1_err", 32'(err), 0); chk("nb1_mcnt", 32'(match_cnt), 1);
      chk("nb1_lock", 32'(locked), 0);
      send(25, 38, 63);   chk("nb2_err", 32'(err), 0); chk("nb2_lock", 32'(locked), 1);
      send(25, 38, 182);  chk("nb3_err", 32'(err), 0);
      send(25, 38, 182);  chk("nb4_err", 32'(err), 0); chk("nb4_mcnt", 32'(match_cnt), 4);
      chk("nb4_ecnt", 32'(err_cnt), 0); chk("nb4_state", 32'(state), 1);

      // single-field error then resync
      send(25, 38, 181);
      chk("se_err", 32'(err), 1); chk("se_fld", 32'(err_field), 3'b100);
      chk("se_fail", 32'(fail), 1); chk("se_state", 32'(state), 2);
      chk("se_ecnt", 32'(err_cnt), 1); chk("se_lock", 32'(locked), 0);
      chk("se_mcnt", 32'(match_cnt), 4);
      send(25, 38, 182);
      chk("rs_err", 32'(err), 0); chk("rs_fld", 32'(err_field), 0);
      chk("rs_mcnt", 32'(match_cnt), 5); chk("rs_state", 32'(state), 2);

      // err_field held across idle, err pulse only one cycle
      send(25, 38, 0);
      chk("h_err", 32'(err), 1); chk("h_ecnt", 32'(err_cnt), 2);
      idle(2);
      chk("h_err_gap", 32'(err), 0); chk("h_fld_gap", 32'(err_field), 3'b100);
      chk("h_ecnt_gap", 32'(err_cnt), 2);
      send(25, 38, 182);
      chk("h_fld_clr", 32'(err_field), 0); chk("h_mcnt", 32'(match_cnt), 6);
      idle(5);
      chk("gap_mcnt", 32'(match_cnt), 6); chk("gap_lock", 32'(locked), 0);
      send(25, 38, 182);
      chk("gap_err", 32'(err), 0); chk("gap_mcnt2", 32'(match_cnt), 7);
      chk("gap_lock2", 32'(locked), 1); chk("gap_fail", 32'(fail), 1);

      // async reset between edges
      #2 RST_N = 1'b0; valid = 1'b0;
      #1 chk_zero("arst");
      @(negedge CLK) RST_N = 1'b1;
      send(1, 2, 3);      chk("ar_prime_err", 32'(err), 0); chk("ar_prime_st", 32'(state), 1);
      send(25, 14, 2);    chk("ar_m_err", 32'(err), 0); chk("ar_m_mcnt", 32'(match_cnt), 1);

      // clr wins over valid
      @(negedge CLK);
      clr = 1'b1; valid = 1'b1; x_in = 25; y_in = 39; z_in = 94;
      @(posedge CLK); #1;
      chk_zero("clr");
      @(negedge CLK) clr = 1'b0;
      valid = 1'b0;
      send(7, 7, 7);      chk("cl_prime_err", 32'(err), 0); chk("cl_prime_mcnt", 32'(match_cnt), 0);
      send(25, 20, 49);   chk("cl_m_err", 32'(err), 0); chk("cl_m_mcnt", 32'(match_cnt), 1);

      // err_cnt saturation, back-to-back pulses
      send(25, 38, 0);    chk("sat0_err", 32'(err), 1);
      for (int i = 0; i < 300; i++) begin
         send(25, 38, 8'(i % 2));
         chk("sat_err", 32'(err), 1);
      end
      chk("sat_ecnt", 32'(err_cnt), 255); chk("sat_mcnt", 32'(match_cnt), 1);

      // match_cnt saturation on the 4-bit instance
      @(negedge CLK) clr = 1'b1; valid = 1'b0;
      @(negedge CLK) clr = 1'b0;
      send(10, 10, 10);
      send(25, 23, 100);
      send(25, 38, 63);
      for (int i = 0; i < 17; i++) send(25, 38, 182);
      chk("ms_mcnt16", 32'(match_cnt), 19); chk("ms_mcnt4", 32'(match_cnt4), 15);
      chk("ms_err4", 32'(err_cnt4), 0);
`endif
      idle(1);
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule

// File: doc/nb_chain_checker.md
# nb_chain_checker

Checker for the three-register update chain driven by the blocking/nonblocking example bench (x <= X_CONST, y <= x+Y_ADD, z <= x*y). Samples the chain's x/y/z once per update, predicts the next triple from the previous one, and flags any deviation from the selected assignment semantics. It sits beside the producer as its reader end, and reports per-sample errors, sticky failure, lock status and saturating statistics.

## Interface
- X_CONST, 25: constant the producer loads into x each update.
- Y_ADD, 13: constant added to x to form the next y.
- LOCK_N, 2: consecutive matching samples required to assert locked (range 1..15).
- CNT_W, 16: width of match_cnt.

- CLK  in  1  clock, all state updates on posedge.
- RST_N  in  1  asynchronous active-low reset.
- clr  in  1  synchronous clear of state, counters and fail.
- valid  in  1  x_in/y_in/z_in carry one updated triple this cycle.
- x_in  in  8  observed x.
- y_in  in  8  observed y.
- z_in  in  8  observed z.
- err  out  1  one-cycle pulse: previous valid sample mismatched.
- err_field  out  3  {z,y,x} mismatch mask for that sample, held until next checked sample.
- fail  out  1  sticky; set on first mismatch.
- locked  out  1  LOCK_N consecutive matches seen since last error or clear.
- match_cnt  out  CNT_W  matching samples, saturating.
- err_cnt  out  8  mismatching samples, saturating at 255.
- state  out  2  0=IDLE, 1=CHECK, 2=FAIL.

## Operation
- IDLE: first valid sample is captured as the reference triple, and no comparison is made. Next state is CHECK.
- CHECK/FAIL: on each valid sample, compare it against the prediction P formed from the stored reference R.
  - Px = X_CONST[7:0].
  - Py = (Rx + Y_ADD) mod 256.
  - Pz = (Rx * Ry) mod 256, using an 8x8 product truncated to the low 8 bits.
- After every compare, R is loaded with the observed sample, not the prediction. The checker resyncs after an error.
- On mismatch:
  - err=1 and err_field = per-field inequality.
  - err_cnt increments.
  - The consecutive-match counter clears, and locked=0.
  - fail=1 and the state moves to FAIL.
- On match:
  - match_cnt increments.
  - The consecutive-match counter increments, saturating at LOCK_N.
  - locked=1 when the counter equals LOCK_N.
  - err_field clears to 0.
- FAIL behaves like CHECK, but fail stays 1 and the state stays FAIL until clr or reset.
- Cycles with valid=0 change nothing: R is held, err=0, counters are held.
- clr=1 returns the state to IDLE and zeroes all outputs and counters. When clr and valid are both high in the same cycle, clr wins and the sample is discarded.

## Timing
- Reset value of every output is 0, and state is IDLE. Reset is asynchronous: asserting RST_N mid-operation clears everything immediately. Release takes effect at the first posedge after deassertion.
- Latency: err, err_field, counters, locked and fail all update at the posedge that samples valid. They are visible one cycle after the sample is presented.
- err is high for exactly one cycle per mismatching sample. Back-to-back mismatches give back-to-back err pulses.
- There is no backpressure: every valid cycle is consumed.

## Configuration
- NBCHK_BLOCKING_EN undefined: the prediction uses nonblocking semantics, as in Operation (Py and Pz use the previous R).
- NBCHK_BLOCKING_EN defined: the prediction uses blocking semantics.
  - Px = X_CONST.
  - Py = (X_CONST + Y_ADD) mod 256.
  - Pz = (X_CONST * Py) mod 256.
  - R is then used only to leave IDLE.
  - All other behaviour is identical.

## Test plan
- Nonblocking sequence. Reset, then valid triples (10,10,10), (25,23,100), (25,38,63), (25,38,182), (25,38,182).
  - Required response: err never asserts, match_cnt=4, err_cnt=0.
  - locked rises after the 3rd sample's update, once 2 matches are counted.
  - state=CHECK.
- Single-field error. In CHECK after (25,38,182), present (25,38,181).
  - Required response: one err pulse with err_field=3'b100, fail=1, state=FAIL, err_cnt=1, locked=0.
  - Next (25,38,182) matches via resync: err=0 and err_field=0.
- Gaps and clear. Insert 5 idle cycles (valid=0) between matching samples.
  - Required response: no counter change during the gap, and the next sample is compared against the last valid one.
  - Then clr and valid high together: all outputs are 0, state=IDLE, and the sample is ignored.
- Saturation. Feed 300 consecutive mismatches (alternating z).
  - Required response: err_cnt holds at 255, and err pulses every valid cycle.
  - Force match_cnt to saturate with CNT_W=4: it holds at 15.
- Async reset mid-stream. Drop RST_N between clock edges while fail=1 and locked=1.
  - Required response: outputs go to 0 before the next posedge.
  - After release, the first valid sample only primes the checker (no err).
- Blocking build. With NBCHK_BLOCKING_EN defined, the sequence (10,10,10), (25,38,182), (25,38,182) gives no err.
  - The nonblocking triple (25,23,100) after the first sample gives err_field=3'b110.
